// File: rtl/seq_stage_ctrl_if.sv
// Handshake bundle between the Y86 sequential-stage controller and its datapath.
// The master side drives fetch/memory status; the slave (controller) drives stage controls.
interface seq_stage_ctrl_if;
    logic        start;
    logic [3:0]  icode;
    logic        imem_error;
    logic        mem_ready;
    logic        dmem_error;
    logic [5:0]  stage_en;
    logic        mem_req;
    logic        cc_we;
    logic        rf_we;
    logic        pc_we;
    logic [2:0]  stat;
    logic        busy;
    logic [31:0] retired;

    modport master (
        output start, icode, imem_error, mem_ready, dmem_error,
        input  stage_en, mem_req, cc_we, rf_we, pc_we, stat, busy, retired
    );
    modport slave (
        input  start, icode, imem_error, mem_ready, dmem_error,
        output stage_en, mem_req, cc_we, rf_we, pc_we, stat, busy, retired
    );
endinterface

// File: rtl/seq_stage_ctrl.sv
// Y86 sequential stage controller: walks FETCH..PCUPDATE, waits on data memory,
// and parks in HALTED with a status code on any fault.
module seq_stage_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input logic            clk,
    input logic            reset,
    seq_stage_ctrl_if.slave bus
);
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPDATE, HALTED
    } state_t;

    state_t      state;
    logic [3:0]  icode_q;
    logic [7:0]  wcnt;
    logic [2:0]  fault;
    logic [31:0] retired_q;
    logic        is_mem;
    logic        is_wb;

    always_comb begin
        is_mem = icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        is_wb  = icode_q inside {4'h2, 4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            icode_q   <= 4'h0;
            wcnt      <= 8'd0;
            fault     <= STAT_AOK;
            retired_q <= 32'd0;
        end else begin
            case (state)
                IDLE: if (bus.start) state <= FETCH;
                FETCH: begin
                    icode_q <= bus.icode;
                    if (bus.imem_error) begin
                        state <= HALTED;
                        fault <= STAT_ADR;
                    end else if (bus.icode > 4'hB) begin
                        state <= HALTED;
                        fault <= STAT_INS;
                    end else if (bus.icode == 4'h0) begin
                        state <= HALTED;
                        fault <= STAT_HLT;
                    end else begin
                        state <= DECODE;
                    end
                end
                DECODE: state <= EXECUTE;
                EXECUTE: begin
                    state <= MEMORY;
                    wcnt  <= 8'd0;
                end
                MEMORY: begin
                    // error beats ready; a ready in the final allowed cycle still completes
                    if (!is_mem) begin
                        state <= WRITEBACK;
                    end else if (bus.dmem_error) begin
                        state <= HALTED;
                        fault <= STAT_ADR;
                    end else if (bus.mem_ready) begin
                        state <= WRITEBACK;
                    end else if (wcnt == 8'(MEM_TIMEOUT - 1)) begin
                        state <= HALTED;
                        fault <= STAT_ADR;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                WRITEBACK: state <= PCUPDATE;
                PCUPDATE: begin
                    retired_q <= retired_q + 32'd1;
                    state     <= FETCH;
                end
                HALTED: state <= HALTED;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are pure decodes of state so an async reset drops them at once.
    always_comb begin
        bus.stage_en = 6'd0;
        bus.mem_req  = 1'b0;
        bus.cc_we    = 1'b0;
        bus.rf_we    = 1'b0;
        bus.pc_we    = 1'b0;
        case (state)
            FETCH:     bus.stage_en = 6'b000001;
            DECODE:    bus.stage_en = 6'b000010;
            EXECUTE: begin
                bus.stage_en = 6'b000100;
                bus.cc_we    = (icode_q == 4'h6);
            end
            MEMORY: begin
                bus.stage_en = 6'b001000;
                bus.mem_req  = is_mem;
            end
            WRITEBACK: begin
                bus.stage_en = 6'b010000;
                bus.rf_we    = is_wb;
            end
            PCUPDATE: begin
                bus.stage_en = 6'b100000;
                bus.pc_we    = 1'b1;
            end
            default: bus.stage_en = 6'd0;
        endcase
        bus.stat    = (state == HALTED) ? fault : STAT_AOK;
        bus.busy    = (state != IDLE) && (state != HALTED);
        bus.retired = retired_q;
    end
endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Self-checking bench for seq_stage_ctrl: directed scenarios plus a randomized
// instruction stream checked against a per-instruction cycle-trace model.
module tb_seq_stage_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    seq_stage_ctrl_if bus ();

    seq_stage_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int unsigned ret_model = 0;

    typedef struct {
        logic [13:0] outs;   // {stage_en, mem_req, cc_we, rf_we, pc_we, stat, busy}
        int unsigned rt;
        logic        rdy, der, ie;
        logic [3:0]  ic;
    } cyc_t;

    function automatic logic [13:0] obs();
        return {bus.stage_en, bus.mem_req, bus.cc_we, bus.rf_we, bus.pc_we, bus.stat, bus.busy};
    endfunction

    function automatic cyc_t mk(logic [5:0] se, logic mr, logic cc, logic rf, logic pc,
                                logic [2:0] st, logic bz, int unsigned rt,
                                logic rdy, logic der, logic ie, logic [3:0] ic);
        cyc_t c;
        c.outs = {se, mr, cc, rf, pc, st, bz};
        c.rt = rt; c.rdy = rdy; c.der = der; c.ie = ie; c.ic = ic;
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.start = 1'b0; bus.icode = 4'h0; bus.imem_error = 1'b0;
        bus.mem_ready = 1'b0; bus.dmem_error = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        ret_model = 0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.icode = 4'h0; bus.imem_error = 1'b0;
        bus.mem_ready = 1'b0; bus.dmem_error = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs() !== {6'h00, 4'b0000, 3'd1, 1'b0}) begin
            errors++; $display("FAIL reset_outs: got %h want %h", obs(), {6'h00, 4'b0000, 3'd1, 1'b0});
        end
        checks++;
        if (bus.retired !== 32'd0) begin
            errors++; $display("FAIL reset_retired: got %0d want 0", bus.retired);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (bus.stage_en !== 6'h00 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL idle_hold: got se=%h busy=%b want se=00 busy=0", bus.stage_en, bus.busy);
        end
    endtask

    task automatic test_nonmem();
        int npc;
        logic [5:0] exp_se;
        do_reset();
        npc = 0;
        bus.icode = 4'h1; bus.start = 1'b1;
        step();
        for (int i = 0; i < 18; i++) begin
            exp_se = 6'd1 << (i % 6);
            checks++;
            if (bus.stage_en !== exp_se) begin
                errors++; $display("FAIL nop_stage_en c%0d: got %h want %h", i, bus.stage_en, exp_se);
            end
            if (bus.pc_we === 1'b1) npc++;
            step();
        end
        checks++;
        if (npc != 3) begin
            errors++; $display("FAIL nop_pc_we_count: got %0d want 3", npc);
        end
        checks++;
        if (bus.retired !== 32'd3) begin
            errors++; $display("FAIL nop_retired: got %0d want 3", bus.retired);
        end
    endtask

    task automatic test_cc_rf();
        do_reset();
        bus.icode = 4'h6; bus.start = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (bus.cc_we !== (i == 2) || bus.rf_we !== (i == 4)) begin
                errors++; $display("FAIL opq_we c%0d: got cc=%b rf=%b want cc=%b rf=%b",
                                   i, bus.cc_we, bus.rf_we, i == 2, i == 4);
            end
            step();
        end
        bus.icode = 4'h4;
        for (int i = 0; i < 6; i++) begin
            bus.mem_ready = (i == 3);
            checks++;
            if (bus.rf_we !== 1'b0 || bus.stage_en !== 6'(1 << i)) begin
                errors++; $display("FAIL rmmov_rf c%0d: got rf=%b se=%h want rf=0 se=%h",
                                   i, bus.rf_we, bus.stage_en, 6'(1 << i));
            end
            step();
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_mem_wait();
        int nreq;
        do_reset();
        bus.icode = 4'h5; bus.start = 1'b1;
        step(); step(); step(); step();
        nreq = 0;
        for (int k = 1; k <= 3; k++) begin
            if (bus.mem_req === 1'b1) nreq++;
            bus.mem_ready = (k == 3);
            step();
        end
        bus.mem_ready = 1'b0;
        checks++;
        if (nreq != 3) begin
            errors++; $display("FAIL mrmov_req_cycles: got %0d want 3", nreq);
        end
        checks++;
        if (bus.stage_en !== 6'h10 || bus.rf_we !== 1'b1 || bus.mem_req !== 1'b0) begin
            errors++; $display("FAIL mrmov_wb: got se=%h rf=%b mr=%b want se=10 rf=1 mr=0",
                               bus.stage_en, bus.rf_we, bus.mem_req);
        end
        step(); step();
        checks++;
        if (bus.retired !== 32'd1 || bus.stage_en !== 6'h01) begin
            errors++; $display("FAIL mrmov_retire: got ret=%0d se=%h want ret=1 se=01", bus.retired, bus.stage_en);
        end
        step(); step(); step();
        bus.mem_ready = 1'b1; bus.dmem_error = 1'b1;
        step();
        bus.mem_ready = 1'b0; bus.dmem_error = 1'b0;
        checks++;
        if (bus.stat !== 3'd3 || bus.busy !== 1'b0 || bus.rf_we !== 1'b0 || bus.stage_en !== 6'h00) begin
            errors++; $display("FAIL derr_halt: got stat=%0d busy=%b rf=%b se=%h want stat=3 busy=0 rf=0 se=00",
                               bus.stat, bus.busy, bus.rf_we, bus.stage_en);
        end
        step();
        checks++;
        if (bus.retired !== 32'd1 || bus.pc_we !== 1'b0) begin
            errors++; $display("FAIL derr_no_retire: got ret=%0d pc=%b want ret=1 pc=0", bus.retired, bus.pc_we);
        end
    endtask

    task automatic test_timeout();
        int nreq;
        do_reset();
        bus.icode = 4'hA; bus.start = 1'b1;
        step(); step(); step(); step();
        nreq = 0;
        while (bus.mem_req === 1'b1 && nreq < 40) begin
            nreq++;
            step();
        end
        checks++;
        if (nreq != 15) begin
            errors++; $display("FAIL timeout_cycles: got %0d want 15", nreq);
        end
        checks++;
        if (bus.stat !== 3'd3 || bus.busy !== 1'b0 || bus.retired !== 32'd0) begin
            errors++; $display("FAIL timeout_halt: got stat=%0d busy=%b ret=%0d want stat=3 busy=0 ret=0",
                               bus.stat, bus.busy, bus.retired);
        end
    endtask

    task automatic test_fetch_faults();
        logic [3:0] fic [3];
        logic       fie [3];
        logic [2:0] fst [3];
        fic = '{4'h0, 4'hC, 4'h0};
        fie = '{1'b0, 1'b0, 1'b1};
        fst = '{3'd2, 3'd4, 3'd3};
        for (int c = 0; c < 3; c++) begin
            do_reset();
            bus.icode = fic[c]; bus.imem_error = fie[c]; bus.start = 1'b1;
            step();
            step();
            checks++;
            if (bus.stat !== fst[c] || bus.stage_en !== 6'h00 || bus.busy !== 1'b0) begin
                errors++; $display("FAIL fetch_fault%0d: got stat=%0d se=%h busy=%b want stat=%0d se=00 busy=0",
                                   c, bus.stat, bus.stage_en, bus.busy, fst[c]);
            end
            bus.icode = 4'h1; bus.imem_error = 1'b0;
            for (int i = 0; i < 4; i++) step();
            checks++;
            if (bus.stat !== fst[c] || bus.stage_en !== 6'h00) begin
                errors++; $display("FAIL halt_sticky%0d: got stat=%0d se=%h want stat=%0d se=00",
                                   c, bus.stat, bus.stage_en, fst[c]);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        bus.icode = 4'h1; bus.start = 1'b1;
        step(); step();
        bus.icode = 4'h9;
        step(); step(); step(); step();
        step(); step(); step(); step(); step();
        checks++;
        if (bus.mem_req !== 1'b1 || bus.retired !== 32'd1) begin
            errors++; $display("FAIL pre_reset_wait: got mr=%b ret=%0d want mr=1 ret=1", bus.mem_req, bus.retired);
        end
        bus.start = 1'b0;
        #3 reset = 1'b1;
        #1;
        checks++;
        if (obs() !== {6'h00, 4'b0000, 3'd1, 1'b0} || bus.retired !== 32'd0) begin
            errors++; $display("FAIL async_reset_mid: got %h ret=%0d want %h ret=0",
                               obs(), bus.retired, {6'h00, 4'b0000, 3'd1, 1'b0});
        end
        step();
        reset = 1'b0;
        step(); step();
        checks++;
        if (bus.pc_we !== 1'b0 || bus.stage_en !== 6'h00 || bus.retired !== 32'd0) begin
            errors++; $display("FAIL post_reset_idle: got pc=%b se=%h ret=%0d want pc=0 se=00 ret=0",
                               bus.pc_we, bus.stage_en, bus.retired);
        end
    endtask

    // Each instruction is expanded into its expected cycle trace, then replayed.
    task automatic test_random();
        cyc_t q[$];
        logic halted;
        logic [3:0] ic;
        logic ie, derr, ismem, iswb;
        int w, r;
        logic [2:0] code;
        halted = 1'b1;
        for (int n = 0; n < 80; n++) begin
            if (halted) begin
                do_reset();
                bus.start = 1'b1;
                step();
                halted = 1'b0;
            end
            r = $urandom_range(0, 23);
            ic = (r < 16) ? 4'(r) : 4'($urandom_range(1, 11));
            ie = ($urandom_range(0, 15) == 0);
            w = $urandom_range(1, 17);
            derr = ($urandom_range(0, 5) == 0);
            ismem = (ic == 4 || ic == 5 || ic == 8 || ic == 9 || ic == 10 || ic == 11);
            iswb = (ic == 2 || ic == 3 || ic == 5 || ic == 6 || ismem) && ic != 4;
            code = ie ? 3'd3 : (ic > 11) ? 3'd4 : (ic == 0) ? 3'd2 : 3'd1;
            q.delete();
            q.push_back(mk(6'h01, 0, 0, 0, 0, 3'd1, 1, ret_model, 0, 0, ie, ic));
            if (code != 3'd1) begin
                q.push_back(mk(6'h00, 0, 0, 0, 0, code, 0, ret_model, 0, 0, 0, 0));
                halted = 1'b1;
            end else begin
                q.push_back(mk(6'h02, 0, 0, 0, 0, 3'd1, 1, ret_model, 0, 0, 0, 0));
                q.push_back(mk(6'h04, 0, ic == 6, 0, 0, 3'd1, 1, ret_model, 0, 0, 0, 0));
                if (ismem) begin
                    for (int k = 1; k <= 15 && k <= w; k++)
                        q.push_back(mk(6'h08, 1, 0, 0, 0, 3'd1, 1, ret_model, k == w && !derr, k == w && derr, 0, 0));
                    if (w > 15 || derr) begin
                        q.push_back(mk(6'h00, 0, 0, 0, 0, 3'd3, 0, ret_model, 0, 0, 0, 0));
                        halted = 1'b1;
                    end
                end else begin
                    q.push_back(mk(6'h08, 0, 0, 0, 0, 3'd1, 1, ret_model, 0, 0, 0, 0));
                end
                if (!halted) begin
                    q.push_back(mk(6'h10, 0, 0, iswb, 0, 3'd1, 1, ret_model, 0, 0, 0, 0));
                    q.push_back(mk(6'h20, 0, 0, 0, 1, 3'd1, 1, ret_model, 0, 0, 0, 0));
                    ret_model++;
                end
            end
            foreach (q[i]) begin
                checks++;
                if (obs() !== q[i].outs || bus.retired !== q[i].rt) begin
                    errors++; $display("FAIL rand_n%0d_c%0d ic=%h: got %h ret=%0d want %h ret=%0d",
                                       n, i, ic, obs(), bus.retired, q[i].outs, q[i].rt);
                end
                bus.icode = (q[i].outs[13:8] == 6'h01) ? q[i].ic : 4'($urandom_range(0, 15));
                bus.imem_error = q[i].ie;
                bus.mem_ready = q[i].rdy;
                bus.dmem_error = q[i].der;
                step();
            end
        end
        bus.mem_ready = 1'b0; bus.dmem_error = 1'b0; bus.imem_error = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nonmem();
        test_cc_rf();
        test_mem_wait();
        test_timeout();
        test_fetch_faults();
        test_reset_mid_mem();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_stage_ctrl.md
SEQ_STAGE_CTRL -- requirements
Module: seq_stage_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, meaning: maximum MEMORY-stage wait cycles before an ADR fault is raised (range 1..255).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  level; begins execution when sampled high in IDLE.
REQ-005 icode  input  4  instruction code from the fetch datapath, valid during FETCH.
REQ-006 imem_error  input  1  instruction memory address fault, sampled in FETCH.
REQ-007 mem_ready  input  1  data memory completion strobe, sampled in MEMORY.
REQ-008 dmem_error  input  1  data memory address fault, sampled in MEMORY.
REQ-009 stage_en  output  6  one-hot stage enable: bit0 FETCH, bit1 DECODE, bit2 EXECUTE, bit3 MEMORY, bit4 WRITEBACK, bit5 PCUPDATE.
REQ-010 mem_req  output  1  data memory request, held high while waiting in MEMORY.
REQ-011 cc_we  output  1  condition-code write enable.
REQ-012 rf_we  output  1  register file write enable.
REQ-013 pc_we  output  1  PC register write enable.
REQ-014 stat  output  3  Y86 status: 1 AOK, 2 HLT, 3 ADR, 4 INS.
REQ-015 busy  output  1  high in any state except IDLE and HALTED.
REQ-016 retired  output  32  count of instructions completed through PCUPDATE.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPDATE, HALTED; stage_en SHALL be one-hot in stage states and 0 in IDLE/HALTED.
REQ-018 IDLE -> FETCH when start=1; otherwise remain IDLE.
REQ-019 FETCH SHALL latch icode into an internal register used by all later stages.
REQ-020 In FETCH, priority: imem_error -> HALTED stat=ADR; else icode>0xB -> HALTED stat=INS; else icode=0x0 -> HALTED stat=HLT; else -> DECODE.
REQ-021 DECODE -> EXECUTE and EXECUTE -> MEMORY unconditionally, one cycle each.
REQ-022 cc_we SHALL be high for exactly the EXECUTE cycle when latched icode=0x6, else low.
REQ-023 Memory instructions are icode 0x4, 0x5, 0x8, 0x9, 0xA, 0xB; for all other icodes MEMORY lasts one cycle with mem_req=0.
REQ-024 For memory instructions, mem_req=1 from MEMORY entry until the cycle mem_ready or dmem_error is sampled high (inclusive).
REQ-025 dmem_error=1 in MEMORY -> HALTED stat=ADR, no WRITEBACK, no pc_we; takes priority over simultaneous mem_ready.
REQ-026 mem_ready=1 (no error) -> WRITEBACK next cycle.
REQ-027 A wait counter SHALL count MEMORY cycles for memory instructions; if MEM_TIMEOUT cycles elapse without mem_ready/dmem_error -> HALTED stat=ADR; counter clears on MEMORY entry.
REQ-028 rf_we SHALL be high for exactly the WRITEBACK cycle when latched icode is 0x2, 0x3, 0x5, 0x6, 0x8, 0x9, 0xA or 0xB, else low.
REQ-029 WRITEBACK -> PCUPDATE unconditionally; pc_we=1 for exactly the PCUPDATE cycle.
REQ-030 PCUPDATE SHALL increment retired by 1 (wrapping 0xFFFFFFFF -> 0) and -> FETCH.
REQ-031 Non-memory instruction latency: 6 cycles FETCH entry to next FETCH entry; memory instruction: 5 + memory wait cycles (minimum 6).
REQ-032 HALTED is sticky; only reset exits it; start is ignored; stat holds the fault code.
REQ-033 stat=1 (AOK) in all states other than HALTED.
REQ-034 cc_we, rf_we, pc_we, mem_req SHALL be combinational decodes of state and latched icode, never asserted outside the stated cycle.

Reset
REQ-035 reset=1 SHALL immediately force IDLE, stage_en=0, mem_req=0, cc_we=0, rf_we=0, pc_we=0, stat=1, busy=0, retired=0, latched icode=0, wait counter=0, regardless of clock.
REQ-036 Reset asserted mid-instruction (any state, including MEMORY with mem_req=1) SHALL abort without pc_we, rf_we or retired increment.
REQ-037 After reset deasserts, FSM remains IDLE until start=1 is sampled.

Verification
REQ-038 reset, start=1, icode=0x1 each FETCH -> stage_en 01,02,04,08,10,20 repeating; pc_we once per 6 cycles; retired=3 after 18 cycles.
REQ-039 icode=0x6 -> cc_we=1 only in EXECUTE cycle, rf_we=1 only in WRITEBACK cycle; icode=0x4 -> rf_we stays 0.
REQ-040 icode=0x5, mem_ready after 3 MEMORY cycles -> mem_req high 3 cycles, WRITEBACK on cycle 4; mem_ready and dmem_error together -> HALTED stat=3, no rf_we.
REQ-041 icode=0xA, mem_ready never with MEM_TIMEOUT=15 -> HALTED stat=3 after 15 MEMORY cycles; retired unchanged.
REQ-042 FETCH with icode=0x0 -> HALTED stat=2; icode=0xC -> stat=4; imem_error with icode=0x0 -> stat=3; start then ignored.
REQ-043 reset pulsed during MEMORY wait -> all outputs reset values asynchronously; retired=0; no pc_we observed.
